sonar_scan_scheduler: RTL and testbench
=======================================

Name: sonar_scan_scheduler

Overview:
- Sequences a bank of HC-SR04 ultrasonic sensors round-robin, one at a time, so their echoes never overlap.
- Per slot it issues the trigger pulse, times the echo with a timeout, and reports a tagged duration in clock cycles.
- It inserts a guard gap before moving to the next sensor.
- It replaces the free-running single-sensor trigger/timer pair and feeds downstream distance and LED logic.

Parameters:
- NUM_SENSORS, 4, number of sensors scanned (min 1).
- TRIG_CYCLES, 120, trigger high time in clocks (10 us at 12 MHz).
- TIMEOUT_CYCLES, 360000, echo wait/measure limit in clocks (30 ms).
- GAP_CYCLES, 120000, guard time between slots in clocks (10 ms).
- ID_W, 2, sensor index width; must satisfy 2**ID_W >= NUM_SENSORS.

Ports:
- clk  in  1  main clock.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  scan enable; sampled only in IDLE and at the end of GAP.
- echo  in  NUM_SENSORS  raw asynchronous echo inputs.
- trigger  out  NUM_SENSORS  trigger outputs; one-hot or zero.
- meas_valid  out  1  one-cycle pulse when a result is issued.
- meas_id  out  ID_W  sensor index of the result.
- meas_duration  out  32  echo high time in clocks.
- meas_timeout  out  1  set when the result timed out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, asynchronous: state IDLE, sensor index 0. All outputs 0: trigger, meas_valid, meas_id, meas_duration, meas_timeout, busy. Synchronizer flops also clear to 0.
- Echo path: each echo bit passes a 2-flop synchronizer (echo_s), plus one delayed copy. Rise = echo_s & ~echo_s_d. Only echo_s[idx] is observed; other sensors' echoes are ignored.
- IDLE: if enable=1, go to TRIG next cycle.
- TRIG:
  - trigger[idx]=1 for exactly TRIG_CYCLES consecutive cycles; all other bits 0.
  - trigger is registered, with no glitches.
  - Then go to WAIT_RISE with the wait counter cleared.
- WAIT_RISE:
  - A rise on echo_s[idx] goes to MEASURE with cnt=1.
  - echo already high on entry (no rise) is not a start; wait for a genuine rise.
  - If TIMEOUT_CYCLES cycles pass with no rise, issue a result with duration=0, timeout=1, then go to GAP.
- MEASURE:
  - While echo_s[idx]=1, cnt increments by 1 per cycle.
  - On the first cycle echo_s[idx]=0, issue duration=cnt, timeout=0. A synchronized high of K cycles therefore reports K.
  - If cnt reaches TIMEOUT_CYCLES while echo is still high, issue duration=TIMEOUT_CYCLES (saturated), timeout=1.
  - Either way go to GAP.
- Result issue:
  - meas_valid=1 for exactly one cycle: the cycle after the deciding event.
  - meas_id, meas_duration and meas_timeout update in that same cycle and hold until the next result.
- GAP:
  - Count GAP_CYCLES.
  - Then advance idx, wrapping NUM_SENSORS-1 -> 0.
  - If enable=1, go to TRIG; else go to IDLE. idx stays advanced in IDLE.
- enable dropped mid-slot: the current slot completes (result plus GAP), then the block goes to IDLE. No partial or aborted results.
- NUM_SENSORS=1: idx is always 0; back-to-back slots are separated by GAP.
- Counters are 32-bit and cannot overflow (TIMEOUT_CYCLES < 2**32).
- Reset asserted mid-slot: immediate return to reset values. trigger drops asynchronously and no result is issued.

Test Plan (use NUM_SENSORS=4, TRIG=4, TIMEOUT=50, GAP=8):
- Nominal slot: enable=1; echo[0] rises 3 cycles after trigger falls and stays high 20 cycles (synchronized) -> trigger[0] high exactly 4 cycles; meas_valid pulse with id=0, duration=20, timeout=0; then 8-cycle gap, then trigger[1].
- Round-robin wrap: echoes of 5, 6, 7 and 8 cycles on sensors 0-3 -> four results with ids 0,1,2,3 and durations 5,6,7,8; the fifth trigger is trigger[0].
- No echo: sensor 2 never rises -> 50 cycles after its trigger falls, result id=2, duration=0, timeout=1.
- Stuck echo: echo[1] rises and stays high -> result id=1, duration=50, timeout=1. An echo[1] already high at the next visit yields no start until it falls and rises again.
- Crosstalk and enable drop: during sensor 0's slot, pulse echo[3] and deassert enable -> echo[3] is ignored; sensor 0's result is issued; after the gap the block enters IDLE with busy=0 and no further triggers.
- Reset mid-MEASURE: assert rst -> trigger=0, busy=0, meas_valid=0 immediately; after release with enable=1, the first trigger is trigger[0].

Source files
------------

// File: rtl/sonar_scan_scheduler.sv
// Round-robin scheduler for a bank of HC-SR04 sonar sensors: trigger one sensor,
// time its echo with a timeout, report a tagged duration, then wait a guard gap.
module sonar_scan_scheduler #(
   parameter int NUM_SENSORS    = 4,
   parameter int TRIG_CYCLES    = 120,
   parameter int TIMEOUT_CYCLES = 360000,
   parameter int GAP_CYCLES     = 120000,
   parameter int ID_W           = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic [NUM_SENSORS-1:0] echo,
   output logic [NUM_SENSORS-1:0] trigger,
   output logic                   meas_valid,
   output logic [ID_W-1:0]        meas_id,
   output logic [31:0]            meas_duration,
   output logic                   meas_timeout,
   output logic                   busy
);

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE,
      GAP
   } state_t;

   localparam logic [31:0]     TRIG_LAST    = 32'(TRIG_CYCLES - 1);
   localparam logic [31:0]     TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0]     TIMEOUT_FULL = 32'(TIMEOUT_CYCLES);
   localparam logic [31:0]     GAP_LAST     = 32'(GAP_CYCLES - 1);
   localparam logic [ID_W-1:0] LAST_ID      = ID_W'(NUM_SENSORS - 1);

   state_t                 state_q;
   logic [ID_W-1:0]        idx_q;
   logic [31:0]            cnt_q;
   logic [NUM_SENSORS-1:0] trigger_q;
   logic                   meas_valid_q;
   logic [ID_W-1:0]        meas_id_q;
   logic [31:0]            meas_duration_q;
   logic                   meas_timeout_q;
   logic                   busy_q;

   logic [NUM_SENSORS-1:0] echo_meta_q;
   logic [NUM_SENSORS-1:0] echo_s_q;
   logic [NUM_SENSORS-1:0] echo_sd_q;

   logic [ID_W-1:0]        idx_next_d;
   logic [NUM_SENSORS-1:0] sel_cur_d;
   logic [NUM_SENSORS-1:0] sel_next_d;
   logic                   echo_cur_d;
   logic                   echo_rise_d;

   // Two-flop synchronizer plus a delayed copy for rising-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         echo_meta_q <= '0;
         echo_s_q    <= '0;
         echo_sd_q   <= '0;
      end else begin
         echo_meta_q <= echo;
         echo_s_q    <= echo_meta_q;
         echo_sd_q   <= echo_s_q;
      end
   end

   always_comb begin
      idx_next_d  = (idx_q == LAST_ID) ? '0 : idx_q + ID_W'(1);
      sel_cur_d   = NUM_SENSORS'(1) << idx_q;
      sel_next_d  = NUM_SENSORS'(1) << idx_next_d;
      echo_cur_d  = |(echo_s_q & sel_cur_d);
      echo_rise_d = |(echo_s_q & ~echo_sd_q & sel_cur_d);
   end

   // Slot sequencer; a single counter is reused by every timed state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         idx_q           <= '0;
         cnt_q           <= '0;
         trigger_q       <= '0;
         meas_valid_q    <= 1'b0;
         meas_id_q       <= '0;
         meas_duration_q <= '0;
         meas_timeout_q  <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         meas_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (enable) begin
                  state_q   <= TRIG;
                  trigger_q <= sel_cur_d;
                  cnt_q     <= '0;
                  busy_q    <= 1'b1;
               end
            end
            TRIG: begin
               if (cnt_q >= TRIG_LAST) begin
                  trigger_q <= '0;
                  state_q   <= WAIT_RISE;
                  cnt_q     <= '0;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            WAIT_RISE: begin
               if (echo_rise_d) begin
                  state_q <= MEASURE;
                  cnt_q   <= 32'd1;
               end else if (cnt_q >= TIMEOUT_LAST) begin
                  meas_valid_q    <= 1'b1;
                  meas_id_q       <= idx_q;
                  meas_duration_q <= '0;
                  meas_timeout_q  <= 1'b1;
                  state_q         <= GAP;
                  cnt_q           <= '0;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            MEASURE: begin
               // The rise cycle already counted as 1, so K high cycles report K.
               if (!echo_cur_d) begin
                  meas_valid_q    <= 1'b1;
                  meas_id_q       <= idx_q;
                  meas_duration_q <= cnt_q;
                  meas_timeout_q  <= 1'b0;
                  state_q         <= GAP;
                  cnt_q           <= '0;
               end else if (cnt_q >= TIMEOUT_LAST) begin
                  meas_valid_q    <= 1'b1;
                  meas_id_q       <= idx_q;
                  meas_duration_q <= TIMEOUT_FULL;
                  meas_timeout_q  <= 1'b1;
                  state_q         <= GAP;
                  cnt_q           <= '0;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            GAP: begin
               if (cnt_q >= GAP_LAST) begin
                  idx_q <= idx_next_d;
                  cnt_q <= '0;
                  if (enable) begin
                     state_q   <= TRIG;
                     trigger_q <= sel_next_d;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            default: begin
               state_q   <= IDLE;
               trigger_q <= '0;
               busy_q    <= 1'b0;
               cnt_q     <= '0;
            end
         endcase
      end
   end

   assign trigger       = trigger_q;
   assign meas_valid    = meas_valid_q;
   assign meas_id       = meas_id_q;
   assign meas_duration = meas_duration_q;
   assign meas_timeout  = meas_timeout_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_sonar_scan_scheduler.sv
// Scoreboard bench for sonar_scan_scheduler: directed echo scenarios push expected
// results into a queue that an independent monitor pops on every meas_valid.
module tb_sonar_scan_scheduler;

   localparam int NS   = 4;
   localparam int TRIG = 4;
   localparam int TMO  = 50;
   localparam int GAP  = 8;
   localparam int IDW  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic [NS-1:0] echo = '0;
   logic [NS-1:0] trigger;
   logic          meas_valid;
   logic [IDW-1:0] meas_id;
   logic [31:0]   meas_duration;
   logic          meas_timeout;
   logic          busy;

   sonar_scan_scheduler #(
      .NUM_SENSORS(NS),
      .TRIG_CYCLES(TRIG),
      .TIMEOUT_CYCLES(TMO),
      .GAP_CYCLES(GAP),
      .ID_W(IDW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .echo(echo),
      .trigger(trigger),
      .meas_valid(meas_valid),
      .meas_id(meas_id),
      .meas_duration(meas_duration),
      .meas_timeout(meas_timeout),
      .busy(busy)
   );

   typedef struct {
      int id;
      int dur;
      int to;
   } result_t;

   result_t expQ[$];
   result_t monExp;
   int      checkCount = 0;
   int      passCount = 0;
   int      cyc = 0;
   int      lastValidCyc = -1000;
   int      lastGap = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // Monitor: every result the DUT presents is matched against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && meas_valid) begin
         lastValidCyc = cyc;
         checkOutput("resultExpected", longint'(expQ.size() > 0), 1);
         if (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            checkOutput("measId", longint'(meas_id), monExp.id);
            checkOutput("measDuration", longint'(meas_duration), monExp.dur);
            checkOutput("measTimeout", longint'(meas_timeout), monExp.to);
         end
      end
   end

   task automatic waitTrig(input int id);
      int n;
      logic [NS-1:0] want;
      want = NS'(1) << id;
      n = 0;
      while (trigger == '0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checkOutput("trigWithinBound", longint'(n < 300), 1);
      lastGap = cyc - lastValidCyc;
      checkOutput("trigSelect", longint'(trigger), longint'(want));
      checkOutput("busyInSlot", longint'(busy), 1);
      n = 0;
      while (trigger == want && n < 100) begin
         n++;
         @(negedge clk);
      end
      checkOutput("trigWidth", n, TRIG);
   endtask

   task automatic applyStimulus(input int id, input int delay, input int dropLen,
                                input int highLen, input bit holdHigh,
                                input int expDur, input int expTo);
      result_t r;
      waitTrig(id);
      r.id = id;
      r.dur = expDur;
      r.to = expTo;
      expQ.push_back(r);
      repeat (delay) @(negedge clk);
      if (dropLen > 0) begin
         echo[id] = 1'b0;
         repeat (dropLen) @(negedge clk);
      end
      if (highLen > 0) begin
         echo[id] = 1'b1;
         repeat (highLen) @(negedge clk);
         if (!holdHigh) echo[id] = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int trigHits;
      result_t r;

      repeat (3) @(negedge clk);
      checkOutput("resetTrigger", longint'(trigger), 0);
      checkOutput("resetValid", longint'(meas_valid), 0);
      checkOutput("resetId", longint'(meas_id), 0);
      checkOutput("resetDuration", longint'(meas_duration), 0);
      checkOutput("resetTimeout", longint'(meas_timeout), 0);
      checkOutput("resetBusy", longint'(busy), 0);

      rst = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("idleBusyDisabled", longint'(busy), 0);
      checkOutput("idleTrigDisabled", longint'(trigger), 0);

      enable = 1'b1;
      applyStimulus(0, 3, 0, 20, 1'b0, 20, 0);
      applyStimulus(1, 3, 0, 6, 1'b0, 6, 0);
      checkOutput("gapLength", lastGap, GAP);
      applyStimulus(2, 2, 0, 7, 1'b0, 7, 0);
      applyStimulus(3, 1, 0, 8, 1'b0, 8, 0);
      applyStimulus(0, 3, 0, 5, 1'b0, 5, 0);

      applyStimulus(1, 2, 0, 1, 1'b1, TMO, 1);
      applyStimulus(2, 0, 0, 0, 1'b0, 0, 1);
      applyStimulus(3, 3, 0, 8, 1'b0, 8, 0);
      applyStimulus(0, 2, 0, 5, 1'b0, 5, 0);
      applyStimulus(1, 4, 3, 6, 1'b0, 6, 0);
      applyStimulus(2, 3, 0, 7, 1'b0, 7, 0);
      applyStimulus(3, 3, 0, 8, 1'b0, 8, 0);

      // Crosstalk on sensor 3 and enable dropped during sensor 0's slot.
      waitTrig(0);
      enable = 1'b0;
      r.id = 0;
      r.dur = 9;
      r.to = 0;
      expQ.push_back(r);
      repeat (2) @(negedge clk);
      echo[3] = 1'b1;
      repeat (4) @(negedge clk);
      echo[3] = 1'b0;
      repeat (6) @(negedge clk);
      echo[0] = 1'b1;
      repeat (9) @(negedge clk);
      echo[0] = 1'b0;
      n = 0;
      while (!meas_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("dropResultSeen", longint'(n < 100), 1);
      repeat (GAP + 1) @(negedge clk);
      checkOutput("idleAfterDropBusy", longint'(busy), 0);
      trigHits = 0;
      repeat (40) begin
         @(negedge clk);
         if (trigger != '0 || busy) trigHits++;
      end
      checkOutput("noActivityWhenIdle", trigHits, 0);

      // Reset asserted while sensor 1 is being measured.
      enable = 1'b1;
      waitTrig(1);
      repeat (2) @(negedge clk);
      echo[1] = 1'b1;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midResetTrigger", longint'(trigger), 0);
      checkOutput("midResetBusy", longint'(busy), 0);
      checkOutput("midResetValid", longint'(meas_valid), 0);
      checkOutput("midResetDuration", longint'(meas_duration), 0);
      repeat (2) @(negedge clk);
      echo[1] = 1'b0;
      rst = 1'b0;
      applyStimulus(0, 3, 0, 5, 1'b0, 5, 0);

      n = 0;
      while (expQ.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checkOutput("queueDrained", expQ.size(), 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
